uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

Transmit-side UART block: accepts bytes from the CPU/bus side into a 4-entry FIFO and serializes them onto the `tx` line as 8N1 frames, LSB first. It is the counterpart of the receive ring buffer, with the data flowing the opposite way. It sits between the Phaethon I/O write port and the board TX pin.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit (50 MHz / 115200). Legal range 2..65535.
- `clk`  in  1  global clock, all state on posedge.
- `reset`  in  1  asynchronous, active-high reset. Clears all state immediately.
- `dataWriteEnable`  in  1  request to enqueue `dataWrite` this cycle.
- `dataWrite`  in  8  byte to transmit.
- `dataWriteAck`  out  1  registered. 1 for exactly one cycle after an accepted write; 0 otherwise, including a dropped write.
- `txFull`  out  1  registered. FIFO holds 4 entries.
- `txEmpty`  out  1  registered. FIFO is empty and the FSM is in IDLE.
- `tx`  out  1  serial line. Registered, idles high.
- `debug`  out  32  bit fields:
  - [31:24] dropped-write count, saturates at 255.
  - [23:16] frames completed, mod 256.
  - [15:8] shift register contents.
  - [7:4] FSM state encoding.
  - [2:0] FIFO count.

## Operation
- FIFO storage:
  - 4×8 storage, 2-bit read and write pointers that wrap 3→0, and a 3-bit count (0..4).
  - Full and empty come from the count only.
- Write accept rule: when `dataWriteEnable`=1 and the registered count is <4:
  - store at the write pointer, write pointer +1;
  - `dataWriteAck`<=1.
- Write reject rule: when `dataWriteEnable`=1 and the count is 4:
  - the byte is dropped and `dataWriteAck`<=0;
  - the drop counter increments.
  - A pop in the same cycle does not rescue the write; full is judged on the pre-edge count.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- FSM states: IDLE, START, DATA, STOP (plus PARITY, see Configuration).
  - IDLE: `tx`=1. If count>0: load the head byte into the shift register, pop, `tx`<=0, go to START.
  - START: hold `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with `tx`<=bit0.
  - DATA: each bit is held `CLKS_PER_BIT` cycles, then the register shifts right. A 3-bit index counts 0..7. After bit7 go to STOP with `tx`<=1.
  - STOP: hold `tx`=1 for `CLKS_PER_BIT` cycles. At the end the frame counter increments. If count>0, load and pop the next byte and enter START directly (no idle gap); otherwise go to IDLE.
- Baud counter:
  - 16-bit, counts 0..`CLKS_PER_BIT`-1.
  - Reset to 0 on every state or bit transition.
- Writes never stall the FSM, and the FSM never blocks writes except when the FIFO is full.

## Timing
- Reset values:
  - `tx`=1, `dataWriteAck`=0, `txFull`=0, `txEmpty`=1, `debug`=0.
  - Pointers, count and counters 0; state IDLE.
- Reset mid-frame: `tx` returns to 1 asynchronously, the frame is aborted, and the FIFO contents are discarded.
- Latency from an accepted write at edge N (FIFO empty, IDLE):
  - `dataWriteAck`=1 after edge N.
  - `tx` falls at edge N+1.
  - Start bit spans edges N+1..N+1+`CLKS_PER_BIT`.
- Frame length is 10×`CLKS_PER_BIT` cycles. Back-to-back frames are contiguous.
- `txEmpty` rises on the edge where STOP→IDLE.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP.
  - It transmits the even-parity bit (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles.
  - Frame length becomes 11×`CLKS_PER_BIT`.
- `UART_TX_PARITY_EN` undefined: no PARITY state, pure 8N1, 10×`CLKS_PER_BIT` frame.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- Reset asserted -> `tx`=1, `txEmpty`=1, `txFull`=0, `dataWriteAck`=0, `debug`=0.
- Write 0xA5 while idle -> `dataWriteAck` pulses for 1 cycle. `tx` gives 4 cycles low, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 4 cycles high; `txEmpty`=1 after 40 cycles.
- 6 consecutive writes 0x01..0x06 from idle -> first 5 acked, 6th dropped with ack 0. `debug[31:24]`=1. Five contiguous frames in 200 cycles with no high gap between stop and start; `debug[23:16]`=5.
- Reset pulsed mid-DATA of 0x3C with 2 bytes queued -> `tx`=1 immediately, `debug[2:0]`=0, no further frames.
- With `UART_TX_PARITY_EN`, write 0x07 -> data bits 1,1,1,0,0,0,0,0, parity bit 1, stop 1; frame is 44 cycles.
- FIFO full and a write issued on the same cycle as the IDLE/STOP pop -> write rejected, count goes 4→3, drop counter +1.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 4-entry byte FIFO feeding an 8N1 LSB-first UART transmitter.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dataWriteEnable,
    input  logic [7:0]  dataWrite,
    output logic        dataWriteAck,
    output logic        txFull,
    output logic        txEmpty,
    output logic        tx,
    output logic [31:0] debug
);
    typedef enum logic [3:0] {IDLE = 4'd0, START = 4'd1, DATA = 4'd2, STOP = 4'd3, PARITY = 4'd4} state_t;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    logic [7:0]  mem [4];
    logic [1:0]  wptr, rptr;
    logic [2:0]  count, count_next, bit_idx;
    logic [7:0]  drops, frames, shreg, head;
    logic [15:0] baud;
    logic        push, pop, bit_end, idle_next;
    state_t      state;
`ifdef UART_TX_PARITY_EN
    logic        par_bit;
`endif
    // Push/pop decisions use the registered count, so a pop never frees room for a same-cycle write.
    always_comb begin
        head       = mem[rptr];
        bit_end    = baud == BAUD_LAST;
        push       = dataWriteEnable && count != 3'd4;
        pop        = count != 3'd0 && (state == IDLE || (state == STOP && bit_end));
        count_next = count + 3'(push) - 3'(pop);
        idle_next  = count == 3'd0 && (state == IDLE || (state == STOP && bit_end));
    end
    // FIFO storage, pointers, occupancy flags, write handshake and drop counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) mem[i] <= '0;
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            drops        <= '0;
            dataWriteAck <= 1'b0;
            txFull       <= 1'b0;
        end else begin
            if (push) begin
                mem[wptr] <= dataWrite;
                wptr      <= wptr + 2'd1;
            end
            if (pop) rptr <= rptr + 2'd1;
            if (dataWriteEnable && !push && drops != 8'hFF) drops <= drops + 8'd1;
            count        <= count_next;
            dataWriteAck <= push;
            txFull       <= count_next == 3'd4;
        end
    end
`ifdef UART_TX_PARITY_EN
    // Even parity of the byte being framed, captured when it leaves the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) par_bit <= 1'b0;
        else if (pop) par_bit <= ^head;
    end
`endif
    // Frame sequencer: one baud period per state/bit, chaining straight from STOP into the next START.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            frames  <= '0;
            tx      <= 1'b1;
            txEmpty <= 1'b1;
        end else begin
            txEmpty <= idle_next && count_next == 3'd0;
            baud    <= (state == IDLE || bit_end) ? 16'd0 : baud + 16'd1;
            case (state)
                IDLE: if (pop) begin
                    shreg <= head;
                    tx    <= 1'b0;
                    state <= START;
                end
                START: if (bit_end) begin
                    tx      <= shreg[0];
                    bit_idx <= '0;
                    state   <= DATA;
                end
                DATA: if (bit_end) begin
                    shreg <= shreg >> 1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx    <= par_bit;
                        state <= PARITY;
`else
                        tx    <= 1'b1;
                        state <= STOP;
`endif
                    end else begin
                        tx      <= shreg[1];
                        bit_idx <= bit_idx + 3'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (bit_end) begin
                    tx    <= 1'b1;
                    state <= STOP;
                end
`endif
                STOP: if (bit_end) begin
                    frames <= frames + 8'd1;
                    if (pop) begin
                        shreg <= head;
                        tx    <= 1'b0;
                        state <= START;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
    assign debug = {drops, frames, shreg, state, 1'b0, count};
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: randomized self-checking bench comparing the serial line against an ideal frame model.
module tb_uart_tx_serializer;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * CPB;
    logic        clk = 1'b0, reset = 1'b1, we = 1'b0;
    logic [7:0]  wd = 8'h00;
    logic        ack, full, empty, tx;
    logic [31:0] debug;
    int          errors = 0, checks = 0;

    uart_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .dataWriteEnable(we), .dataWrite(wd),
        .dataWriteAck(ack), .txFull(full), .txEmpty(empty), .tx(tx), .debug(debug)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Ideal line level for bit slot i of a frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
        if (i == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic do_reset;
        reset = 1'b1;
        we = 1'b0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    // Called just after the edge where the start bit begins; returns just after the frame's last edge.
    task automatic check_frame(input logic [7:0] b, input string name);
        int bad = -1;
        int busy_bad = -1;
        logic got = 1'b0;
        logic want = 1'b0;
        for (int k = 0; k < FL; k++) begin
            if (bad < 0 && tx !== frame_bit(b, k / CPB)) begin
                bad = k;
                got = tx;
                want = frame_bit(b, k / CPB);
            end
            if (busy_bad < 0 && empty !== 1'b0) busy_bad = k;
            tick;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: frame 0x%02h cycle %0d tx=%b expected %b", name, b, bad, got, want);
        end
        checks++;
        if (busy_bad >= 0) begin
            errors++;
            $display("FAIL %s_busy: txEmpty=1 at frame cycle %0d expected 0", name, busy_bad);
        end
    endtask

    task automatic send_one(input logic [7:0] b, input string name);
        we = 1'b1;
        wd = b;
        tick;
        we = 1'b0;
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL %s_ack: ack=%b expected 1", name, ack); end
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL %s_pre: tx=%b expected 1", name, tx); end
        tick;
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL %s_ack_pulse: ack=%b expected 0", name, ack); end
        check_frame(b, name);
        checks++;
        if (empty !== 1'b1 || tx !== 1'b1) begin
            errors++;
            $display("FAIL %s_end: txEmpty=%b tx=%b expected 1 1", name, empty, tx);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (empty !== 1'b1 && n < 400) begin
            tick;
            n++;
        end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL %s_drain: txEmpty=%b expected 1 within 400 cycles", name, empty); end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: tx=%b expected 1", tx); end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: txEmpty=%b expected 1", empty); end
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL reset_full: txFull=%b expected 0", full); end
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: ack=%b expected 0", ack); end
        checks++;
        if (debug !== 32'h0) begin errors++; $display("FAIL reset_debug: debug=%h expected 0", debug); end
        reset = 1'b0;
    endtask

    task automatic test_single;
        do_reset;
        send_one(8'hA5, "single_a5");
        checks++;
        if (debug[23:16] !== 8'd1) begin errors++; $display("FAIL single_frames: frames=%0d expected 1", debug[23:16]); end
    endtask

    task automatic test_random_frames;
        do_reset;
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 5)) tick;
            send_one(8'($urandom), "random_frame");
        end
        checks++;
        if (debug[23:16] !== 8'd6) begin errors++; $display("FAIL random_frames_count: frames=%0d expected 6", debug[23:16]); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] b1, b2;
        do_reset;
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        we = 1'b1;
        wd = b1;
        tick;
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL b2b_ack1: ack=%b expected 1", ack); end
        wd = b2;
        tick;
        we = 1'b0;
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL b2b_ack2: ack=%b expected 1", ack); end
        check_frame(b1, "b2b_first");
        check_frame(b2, "b2b_second");
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: txEmpty=%b expected 1", empty); end
    endtask

    task automatic test_burst;
        logic acks [6];
        do_reset;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    we = 1'b1;
                    wd = 8'(i + 1);
                    tick;
                    acks[i] = ack;
                end
                we = 1'b0;
            end
            begin
                tick;
                tick;
                for (int f = 0; f < 5; f++) check_frame(8'(f + 1), "burst_frame");
            end
        join
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (acks[i] !== (i < 5)) begin errors++; $display("FAIL burst_ack%0d: ack=%b expected %b", i, acks[i], i < 5); end
        end
        checks++;
        if (debug[31:24] !== 8'd1) begin errors++; $display("FAIL burst_drops: drops=%0d expected 1", debug[31:24]); end
        checks++;
        if (debug[23:16] !== 8'd5) begin errors++; $display("FAIL burst_frames: frames=%0d expected 5", debug[23:16]); end
        checks++;
        if (empty !== 1'b1 || tx !== 1'b1) begin errors++; $display("FAIL burst_end: txEmpty=%b tx=%b expected 1 1", empty, tx); end
    endtask

    task automatic test_reset_mid_frame;
        int hi_bad = 0;
        do_reset;
        we = 1'b1;
        wd = 8'h3C;
        tick;
        wd = 8'($urandom);
        tick;
        wd = 8'($urandom);
        tick;
        we = 1'b0;
        repeat (6) tick;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL midreset_tx: tx=%b expected 1", tx); end
        checks++;
        if (debug !== 32'h0) begin errors++; $display("FAIL midreset_debug: debug=%h expected 0", debug); end
        tick;
        reset = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (tx !== 1'b1) hi_bad++;
            tick;
        end
        checks++;
        if (hi_bad != 0) begin errors++; $display("FAIL midreset_quiet: tx low for %0d cycles expected 0", hi_bad); end
        checks++;
        if (debug !== 32'h0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL midreset_after: debug=%h txEmpty=%b expected 0 1", debug, empty);
        end
    endtask

    task automatic test_full_pop_collision;
        logic [7:0] y [4];
        int ack_bad = 0;
        do_reset;
        for (int i = 0; i < 4; i++) y[i] = 8'($urandom);
        we = 1'b1;
        wd = 8'($urandom);
        tick;
        if (ack !== 1'b1) ack_bad++;
        for (int i = 0; i < 4; i++) begin
            wd = y[i];
            tick;
            if (ack !== 1'b1) ack_bad++;
        end
        we = 1'b0;
        checks++;
        if (ack_bad != 0) begin errors++; $display("FAIL collide_fill_acks: %0d missing acks expected 0", ack_bad); end
        repeat (FL - 4) tick;
        checks++;
        if (full !== 1'b1 || debug[2:0] !== 3'd4) begin
            errors++;
            $display("FAIL collide_full: txFull=%b count=%0d expected 1 4", full, debug[2:0]);
        end
        we = 1'b1;
        wd = 8'($urandom);
        tick;
        we = 1'b0;
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL collide_ack: ack=%b expected 0", ack); end
        checks++;
        if (debug[2:0] !== 3'd3 || full !== 1'b0) begin
            errors++;
            $display("FAIL collide_count: count=%0d txFull=%b expected 3 0", debug[2:0], full);
        end
        checks++;
        if (debug[31:24] !== 8'd1) begin errors++; $display("FAIL collide_drops: drops=%0d expected 1", debug[31:24]); end
        for (int i = 0; i < 4; i++) check_frame(y[i], "collide_frame");
        checks++;
        if (empty !== 1'b1 || debug[23:16] !== 8'd5) begin
            errors++;
            $display("FAIL collide_end: txEmpty=%b frames=%0d expected 1 5", empty, debug[23:16]);
        end
    endtask

    task automatic test_drop_saturation;
        int acc = 0;
        do_reset;
        we = 1'b1;
        for (int i = 0; i < 400; i++) begin
            wd = 8'($urandom);
            tick;
            if (ack === 1'b1) acc++;
        end
        we = 1'b0;
        checks++;
        if (debug[31:24] !== 8'd255) begin errors++; $display("FAIL sat_drops: drops=%0d expected 255", debug[31:24]); end
        wait_idle("sat");
        checks++;
        if (debug[23:16] !== 8'(acc)) begin errors++; $display("FAIL sat_frames: frames=%0d expected %0d", debug[23:16], 8'(acc)); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_random_frames;
        test_back_to_back;
        test_burst;
        test_reset_mid_frame;
        test_full_pop_collision;
        test_drop_saturation;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
